nios_system_nios2_processor_div_cell: RTL and testbench
=======================================================

// Module: nios_system_nios2_processor_div_cell
// PURPOSE
//  Iterative radix-2 restoring divider cell for the Nios II processor's div/divu path.
//  It is the inverse-operation companion to the multiplier cell.
//  Operands are presented with a one-cycle start pulse. The result is produced after a
//  fixed latency and held with a done pulse, for the A-stage stall logic.
//  Supports signed and unsigned operation. The quotient or remainder is selected at start.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width in bits; iteration count equals DATA_WIDTH
// PORTS
//  clk                input   1           rising-edge clock
//  reset              input   1           synchronous, active-high reset
//  A_div_src1         input   DATA_WIDTH  dividend, sampled when a start is accepted
//  A_div_src2         input   DATA_WIDTH  divisor, sampled when a start is accepted
//  A_div_signed       input   1           1 = two's-complement operands; sampled at start
//  A_div_rem          input   1           1 = return remainder, 0 = quotient; sampled at start
//  A_div_start        input   1           one-cycle request pulse
//  A_div_busy         output  1           high while in RUN or FIXUP
//  A_div_done         output  1           one-cycle pulse; result valid from this cycle
//  A_div_cell_result  output  DATA_WIDTH  quotient or remainder; held until next start
// BEHAVIOUR
//  Reset (sync, active-high)
//   - state=IDLE; A_div_busy=0; A_div_done=0; A_div_cell_result=0; counter=0.
//   - Reset wins over a simultaneous start.
//   - Reset mid-operation aborts the divide and outputs no done.
//  States: IDLE, RUN, FIXUP, DONE.
//   - IDLE: start=1 -> latch operands/flags. Take magnitudes if signed. Go to RUN with counter=0.
//   - RUN: one restoring step per cycle.
//       rem' = {rem, quo[MSB]} - divisor. If non-negative, keep it and shift 1 into quo;
//       otherwise restore and shift 0 into quo.
//       After DATA_WIDTH steps (counter==DATA_WIDTH-1), go to FIXUP.
//   - FIXUP: apply signs and special cases; register the selected result; go to DONE.
//   - DONE: A_div_done=1 for exactly this cycle.
//       start=1 here -> accepted as in IDLE (back-to-back); else go to IDLE.
//  Latency
//   - Start sampled at edge E -> A_div_done high in cycle after edge E+DATA_WIDTH+1.
//   - That is DATA_WIDTH+2 cycles, i.e. 34 for the default.
//   - A_div_busy is high from E+1 through FIXUP.
//  Handshake
//   - Start while busy (RUN/FIXUP) is ignored; the operation in flight is unaffected.
//   - Operand changes after the start edge have no effect.
//   - A_div_cell_result changes only on the FIXUP->DONE edge and on reset.
//  Arithmetic
//   - Unsigned: q = floor(src1/src2), r = src1 - q*src2.
//   - Signed: truncation toward zero. sign(q) = sign(src1) ^ sign(src2); sign(r) = sign(src1).
//   - Magnitudes use a DATA_WIDTH+1-bit remainder, so |MIN| = 2^(DATA_WIDTH-1) is exact.
//   - Signed MIN / -1: q=MIN (wraps), r=0. No trap or flag.
//   - Divide by zero (signed or unsigned): q = all-ones, r = src1 unmodified.
//       Forced in FIXUP; latency is unchanged.
//   - Zero dividend: q=0, r=0.
// TESTING
//  1. unsigned 100/7, rem=0 then rem=1 -> result 14, then 2; done exactly 34 cycles after start.
//  2. signed 0xFFFFFFF9/2 (-7/2) -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7/-2 -> q=0xFFFFFFFD, r=1.
//  3. divide by zero, src1=0x12345678, signed and unsigned -> q=0xFFFFFFFF, r=0x12345678.
//  4. signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; unsigned same operands -> q=0, r=0x80000000.
//  5. start pulses at cycles 5 and 20 of a run -> ignored; single done; result from first operands.
//  6. reset at cycle 10 of a run -> busy=0, result=0, no done.
//     Start in DONE cycle -> second result 34 cycles later.

Source files
------------

// File: rtl/nios_system_nios2_processor_div_cell.sv
// Iterative radix-2 restoring divider for the Nios II div/divu path.
// One quotient bit per cycle, then a sign/special-case fixup cycle and a one-cycle done pulse.
module nios_system_nios2_processor_div_cell #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] A_div_src1,
    input  logic [DATA_WIDTH-1:0] A_div_src2,
    input  logic                  A_div_signed,
    input  logic                  A_div_rem,
    input  logic                  A_div_start,
    output logic                  A_div_busy,
    output logic                  A_div_done,
    output logic [DATA_WIDTH-1:0] A_div_cell_result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIXUP,
        S_DONE
    } state_t;

    // Two's-complement negate when neg is set; |MIN| maps onto itself, which the
    // unsigned magnitude path treats as 2^(W-1).
    function automatic logic [W-1:0] cond_negate(input logic [W-1:0] v, input logic neg);
        logic signed [W-1:0] sv;
        sv = $signed(v);
        return neg ? $unsigned(-sv) : v;
    endfunction

    state_t          state_q,  state_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic [W-1:0]    result_q, result_d;

    logic [W:0]      rem_q,    rem_d;
    logic [W-1:0]    quo_q,    quo_d;
    logic [W:0]      dvs_q,    dvs_d;
    logic [W-1:0]    src1_q,   src1_d;
    logic            neg_q_q,  neg_q_d;
    logic            neg_r_q,  neg_r_d;
    logic            sel_r_q,  sel_r_d;
    logic            dz_q,     dz_d;

    logic            accept;
    logic            s1_neg;
    logic            s2_neg;
    logic [W+1:0]    shifted;
    logic            fits;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        src1_d   = src1_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        sel_r_d  = sel_r_q;
        dz_d     = dz_q;

        accept   = A_div_start && ((state_q == S_IDLE) || (state_q == S_DONE));
        s1_neg   = A_div_signed && A_div_src1[W-1];
        s2_neg   = A_div_signed && A_div_src2[W-1];

        // Partial remainder shifted left with the next dividend bit; compare on the
        // full width so the carry out of the remainder is never lost.
        shifted  = {rem_q, quo_q[W-1]};
        fits     = (shifted >= {1'b0, dvs_q});

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    quo_d   = cond_negate(A_div_src1, s1_neg);
                    rem_d   = '0;
                    dvs_d   = {1'b0, cond_negate(A_div_src2, s2_neg)};
                    src1_d  = A_div_src1;
                    neg_q_d = s1_neg ^ s2_neg;
                    neg_r_d = s1_neg;
                    sel_r_d = A_div_rem;
                    dz_d    = (A_div_src2 == '0);
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                rem_d = fits ? (shifted[W:0] - dvs_q) : shifted[W:0];
                quo_d = {quo_q[W-2:0], fits};
                if (cnt_q == LAST_STEP) begin
                    cnt_d   = '0;
                    state_d = S_FIXUP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_FIXUP: begin
                if (dz_q) begin
                    result_d = sel_r_q ? src1_q : '1;
                end else if (sel_r_q) begin
                    result_d = cond_negate(rem_q[W-1:0], neg_r_q);
                end else begin
                    result_d = cond_negate(quo_q, neg_q_q);
                end
                state_d = S_DONE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Datapath registers carry no reset; the control state decides when they matter.
    always_ff @(posedge clk) begin
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        dvs_q   <= dvs_d;
        src1_q  <= src1_d;
        neg_q_q <= neg_q_d;
        neg_r_q <= neg_r_d;
        sel_r_q <= sel_r_d;
        dz_q    <= dz_d;
    end

    assign A_div_busy        = (state_q == S_RUN) || (state_q == S_FIXUP);
    assign A_div_done        = (state_q == S_DONE);
    assign A_div_cell_result = result_q;

endmodule

// File: tb/tb_nios_system_nios2_processor_div_cell.sv
// Directed and model-checked bench for the iterative divider cell.
module tb_nios_system_nios2_processor_div_cell;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] src1, src2;
    logic        sgn, rem, start;
    logic        busy, done;
    logic [31:0] res;

    int          nvec = 0;
    int          nbad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;
    int          n;
    int          dcount;

    nios_system_nios2_processor_div_cell #(.DATA_WIDTH(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .A_div_src1        (src1),
        .A_div_src2        (src2),
        .A_div_signed      (sgn),
        .A_div_rem         (rem),
        .A_div_start       (start),
        .A_div_busy        (busy),
        .A_div_done        (done),
        .A_div_cell_result (res)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nbad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic r);
        longint sa, sb, q, rm;
        if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = sa / sb;
        rm = sa % sb;
        return r ? rm[31:0] : q[31:0];
    endfunction

    // Drive a one-cycle start; operands are scrambled afterwards to prove they were latched.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic r, input logic [31:0] e, input bit now);
        if (!now) @(negedge clk);
        src1 = a; src2 = b; sgn = s; rem = r; start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0; src1 = $urandom; src2 = $urandom; sgn = ~s; rem = ~r;
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] e;
        int k;
        k = 1;
        while (done !== 1'b1 && k < 100) begin
            if (k == 17) chk({tag, " held"}, res, last_res);
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'd34);
        if (done === 1'b1) begin
            e = exp_q.pop_front();
            chk(tag, res, e);
            last_res = e;
        end else begin
            void'(exp_q.pop_front());
        end
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic r, input logic [31:0] e);
        issue(a, b, s, r, e, 1'b0);
        wait_done(tag);
        @(negedge clk);
        chk({tag, " done pulse"}, 32'(done), 32'd0);
        chk({tag, " idle busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] a, b, e;
        logic        s, r;

        reset = 1'b1; start = 1'b0; src1 = '0; src2 = '0; sgn = 1'b0; rem = 1'b0;
        last_res = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", res, 32'd0);

        // Start coincident with reset must be dropped.
        src1 = 32'd50; src2 = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("reset beats start busy", 32'(busy), 32'd0);

        op("u 100/7 q", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14);
        op("u 100/7 r", 32'd100, 32'd7, 1'b0, 1'b1, 32'd2);
        op("s -7/2 q", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD);
        op("s -7/2 r", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF);
        op("s 7/-2 q", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'hFFFF_FFFD);
        op("s 7/-2 r", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'd1);
        op("dz s q", 32'h1234_5678, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        op("dz s r", 32'h1234_5678, 32'd0, 1'b1, 1'b1, 32'h1234_5678);
        op("dz u q", 32'h1234_5678, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        op("dz u r", 32'h1234_5678, 32'd0, 1'b0, 1'b1, 32'h1234_5678);
        op("min/-1 s q", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000);
        op("min/-1 s r", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0);
        op("min/-1 u q", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        op("min/-1 u r", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000);
        op("zero dividend q", 32'd0, 32'd9, 1'b1, 1'b0, 32'd0);
        op("zero dividend r", 32'd0, 32'hFFFF_FFF7, 1'b1, 1'b1, 32'd0);
        op("u max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'hFFFF_FFFF);

        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = i[0] ? $urandom : $urandom_range(1, 1000);
            s = i[1];
            r = i[2];
            e = model(a, b, s, r);
            op($sformatf("rand%0d", i), a, b, s, r, e);
        end

        // Starts while busy are ignored.
        issue(32'd1000, 32'd10, 1'b0, 1'b0, 32'd100, 1'b0);
        n = 1;
        while (done !== 1'b1 && n < 100) begin
            if (n == 10) chk("busy in run", 32'(busy), 32'd1);
            @(negedge clk);
            n++;
            start = (n == 5 || n == 20);
            if (start) begin src1 = 32'd7; src2 = 32'd1; sgn = 1'b1; rem = 1'b1; end
        end
        start = 1'b0;
        chk("ignored start latency", 32'(n), 32'd34);
        if (done === 1'b1) chk("ignored start result", res, exp_q.pop_front());
        else void'(exp_q.pop_front());
        last_res = 32'd100;
        dcount = 0;
        repeat (40) begin @(negedge clk); if (done === 1'b1) dcount++; end
        chk("single done", 32'(dcount), 32'd0);

        // Reset in the middle of a run.
        issue(32'h0000_FFFF, 32'd3, 1'b0, 1'b0, 32'h0000_5555, 1'b0);
        void'(exp_q.pop_back());
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort result", res, 32'd0);
        last_res = '0;
        dcount = 0;
        repeat (40) begin @(negedge clk); if (done === 1'b1) dcount++; end
        chk("abort no done", 32'(dcount), 32'd0);

        // Back-to-back: second start presented in the done cycle.
        issue(32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 1'b0);
        wait_done("b2b first");
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, 1'b1);
        chk("b2b busy", 32'(busy), 32'd1);
        wait_done("b2b second");
        @(negedge clk);
        chk("b2b idle", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
